// File: rtl/or1k_boot_pkg.sv
// Shared definitions for the OR1K SPI boot loader: state encoding,
// flash command byte and SPI transfer widths.
package or1k_boot_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE = 4'd0;
  localparam state_t ST_CMD  = 4'd1;
  localparam state_t ST_ADDR = 4'd2;
  localparam state_t ST_LEN  = 4'd3;
  localparam state_t ST_DATA = 4'd4;
  localparam state_t ST_WR   = 4'd5;
  localparam state_t ST_CHK  = 4'd6;
  localparam state_t ST_FIN  = 4'd7;
  localparam state_t ST_ERR  = 4'd8;

  localparam logic [7:0] SPI_READ_CMD = 8'h03;

  // Length, data and checksum words are all this wide on the wire.
  localparam int WORD_W = 32;

  localparam logic [5:0] CMD_BITS  = 6'd8;
  localparam logic [5:0] ADDR_BITS = 6'd24;

endpackage

// File: rtl/or1k_spi_boot_loader_if.sv
// Wishbone write-only bus between the boot loader (master) and the
// system interconnect (slave).
interface or1k_spi_boot_loader_if;

  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;

  modport master (output adr, dat, sel, we, cyc, stb, input ack, err);
  modport slave  (input adr, dat, sel, we, cyc, stb, output ack, err);

endinterface

// File: rtl/spi_shift_engine.sv
// Bit-level SPI mode 0 serializer. Shifts nbits (1..32) out MSB first from
// tx_word and collects the same number of bits into rx_word. SCK half
// period is SCK_DIV wb_clk cycles. While pause is high and SCK is low the
// engine freezes, so SCK can be parked low without dropping chip select.
module spi_shift_engine #(
  parameter int SCK_DIV = 2
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        start,
  input  logic [5:0]  nbits,
  input  logic [31:0] tx_word,
  input  logic        pause,
  output logic        busy,
  output logic [31:0] rx_word,
  output logic        bit_done,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bits_left;
  logic [31:0]      tx_sr;

  // MOSI is the top of the left-aligned shift register; it only moves on
  // the edge that lowers SCK (or at load time, when SCK is already low).
  assign spi_mosi = tx_sr[31];

  // Half-period divider, SCK toggling, MISO capture on the rising edge and
  // TX shift plus bit count on the falling edge.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      busy      <= 1'b0;
      rx_word   <= '0;
      bit_done  <= 1'b0;
      spi_sck   <= 1'b0;
      div_cnt   <= '0;
      bits_left <= '0;
      tx_sr     <= '0;
    end else begin
      bit_done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy      <= 1'b1;
          div_cnt   <= '0;
          bits_left <= nbits;
          tx_sr     <= tx_word << (6'd32 - nbits);
          rx_word   <= '0;
        end
      end else if (!(pause && !spi_sck)) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          if (!spi_sck) begin
            spi_sck <= 1'b1;
            rx_word <= {rx_word[30:0], spi_miso};
          end else begin
            spi_sck   <= 1'b0;
            tx_sr     <= {tx_sr[30:0], 1'b0};
            bit_done  <= 1'b1;
            bits_left <= bits_left - 6'd1;
            if (bits_left == 6'd1) begin
              busy <= 1'b0;
            end
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/or1k_spi_boot_loader.sv
// OR1K hardware boot sequencer. Reads a length-prefixed image from SPI
// flash (READ 0x03 at FLASH_OFFSET) and writes it word by word to RAM at
// RAM_BASE over Wishbone, holding the CPU in reset until the copy succeeds.
// Optional feature: define BOOT_CHECKSUM_EN to require a trailing 32-bit
// additive checksum word after the image data.
module or1k_spi_boot_loader
  import or1k_boot_pkg::*;
#(
  parameter logic [23:0] FLASH_OFFSET = 24'h000000,
  parameter logic [31:0] RAM_BASE     = 32'h00000000,
  parameter int          MAX_WORDS    = 16384,
  parameter int          SCK_DIV      = 2
) (
  input  logic                          wb_clk,
  input  logic                          wb_rst_n,
  output logic                          spi_sck_o,
  output logic                          spi_cs_n_o,
  output logic                          spi_mosi_o,
  input  logic                          spi_miso_i,
  or1k_spi_boot_loader_if.master        wbm,
  output logic                          cpu_rst_o,
  output logic                          done_o,
  output logic                          err_o
);

  state_t      state;
  state_t      state_next;

  logic        launched;
  logic        shift_start;
  logic [5:0]  shift_nbits;
  logic [31:0] shift_tx;
  logic        shift_pause;
  logic        shift_busy;
  logic [31:0] shift_rx;
  logic        shift_bit_done;
  logic        xfer_done;

  logic [31:0] len_q;
  logic [31:0] word_q;
  logic [14:0] word_idx;
  logic        last_word;

`ifdef BOOT_CHECKSUM_EN
  logic [31:0] csum_q;
`endif

  // A transfer has finished on the cycle its final bit completes and the
  // engine has gone idle.
  assign xfer_done   = shift_bit_done & ~shift_busy;
  assign last_word   = ({17'd0, word_idx} == (len_q - 32'd1));
  assign shift_pause = (state == ST_WR);

  spi_shift_engine #(
    .SCK_DIV (SCK_DIV)
  ) u_shift (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .start    (shift_start),
    .nbits    (shift_nbits),
    .tx_word  (shift_tx),
    .pause    (shift_pause),
    .busy     (shift_busy),
    .rx_word  (shift_rx),
    .bit_done (shift_bit_done),
    .spi_sck  (spi_sck_o),
    .spi_mosi (spi_mosi_o),
    .spi_miso (spi_miso_i)
  );

  // State register.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic for the boot sequence.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: state_next = ST_CMD;
      ST_CMD:  if (xfer_done) state_next = ST_ADDR;
      ST_ADDR: if (xfer_done) state_next = ST_LEN;
      ST_LEN: begin
        if (xfer_done) begin
          if (shift_rx == 32'd0) begin
            state_next = ST_FIN;
          end else if (shift_rx > 32'(MAX_WORDS)) begin
            state_next = ST_ERR;
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: if (xfer_done) state_next = ST_WR;
      ST_WR: begin
        if (wbm.err) begin
          state_next = ST_ERR;
        end else if (wbm.ack) begin
          if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
            state_next = ST_CHK;
`else
            state_next = ST_FIN;
`endif
          end else begin
            state_next = ST_DATA;
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CHK: begin
        if (xfer_done) begin
          state_next = (shift_rx == csum_q) ? ST_FIN : ST_ERR;
        end
      end
`endif
      ST_FIN:  state_next = ST_FIN;
      ST_ERR:  state_next = ST_ERR;
      default: state_next = ST_ERR;
    endcase
  end

  // Outputs decoded from the current state: SPI transfer requests, chip
  // select, Wishbone drive and CPU/status signals.
  always_comb begin
    shift_start = 1'b0;
    shift_nbits = 6'(WORD_W);
    shift_tx    = '0;
    spi_cs_n_o  = 1'b1;
    wbm.adr     = '0;
    wbm.dat     = '0;
    wbm.sel     = 4'h0;
    wbm.we      = 1'b0;
    wbm.cyc     = 1'b0;
    wbm.stb     = 1'b0;
    cpu_rst_o   = 1'b1;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (state)
      ST_CMD: begin
        spi_cs_n_o  = 1'b0;
        shift_start = ~launched;
        shift_nbits = CMD_BITS;
        shift_tx    = {24'd0, SPI_READ_CMD};
      end
      ST_ADDR: begin
        spi_cs_n_o  = 1'b0;
        shift_start = ~launched;
        shift_nbits = ADDR_BITS;
        shift_tx    = {8'd0, FLASH_OFFSET};
      end
      ST_LEN, ST_DATA, ST_CHK: begin
        spi_cs_n_o  = 1'b0;
        shift_start = ~launched;
      end
      ST_WR: begin
        spi_cs_n_o = 1'b0;
        wbm.adr    = RAM_BASE + {15'd0, word_idx, 2'b00};
        wbm.dat    = word_q;
        wbm.sel    = 4'hF;
        wbm.we     = 1'b1;
        wbm.cyc    = 1'b1;
        wbm.stb    = 1'b1;
      end
      ST_FIN: begin
        cpu_rst_o = 1'b0;
        done_o    = 1'b1;
      end
      ST_ERR: begin
        err_o = 1'b1;
      end
      default: ;
    endcase
  end

  // One SPI transfer per visit to a shift state: remember that it was
  // launched and re-arm whenever the state changes.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      launched <= 1'b0;
    end else if (state_next != state) begin
      launched <= 1'b0;
    end else if (shift_start) begin
      launched <= 1'b1;
    end
  end

  // Image length, current data word and RAM word index.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      len_q    <= '0;
      word_q   <= '0;
      word_idx <= '0;
    end else begin
      if (state == ST_LEN && xfer_done) begin
        len_q    <= shift_rx;
        word_idx <= '0;
      end
      if (state == ST_DATA && xfer_done) begin
        word_q <= shift_rx;
      end
      if (state == ST_WR && wbm.ack && !wbm.err && !last_word) begin
        word_idx <= word_idx + 15'd1;
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  // Running modulo-2^32 sum of every data word, cleared while reading LEN.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      csum_q <= '0;
    end else if (state == ST_LEN) begin
      csum_q <= '0;
    end else if (state == ST_DATA && xfer_done) begin
      csum_q <= csum_q + shift_rx;
    end
  end
`endif

endmodule
